// File: rtl/acc_dualwb_serializer_if.sv
// Response-in / writeback-out bundle for the dual-writeback serializer.
// The master drives responses and writeback ready; the slave is the serializer.
interface acc_dualwb_serializer_if #(
  parameter int DataWidth = 32
);
  logic [2*DataWidth-1:0] in_data;
  logic                   in_dualwb;
  logic [DataWidth-1:0]   in_hart_id;
  logic [4:0]             in_rd;
  logic                   in_error;
  logic                   in_valid;
  logic                   in_ready;

  logic [DataWidth-1:0]   out_data;
  logic [DataWidth-1:0]   out_hart_id;
  logic [4:0]             out_rd;
  logic                   out_error;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output in_data, in_dualwb, in_hart_id, in_rd, in_error, in_valid, out_ready,
    input  in_ready, out_data, out_hart_id, out_rd, out_error, out_last, out_valid, busy
  );

  modport slave (
    input  in_data, in_dualwb, in_hart_id, in_rd, in_error, in_valid, out_ready,
    output in_ready, out_data, out_hart_id, out_rd, out_error, out_last, out_valid, busy
  );
endinterface

// File: rtl/acc_dualwb_serializer.sv
// Buffers accelerator responses and splits dual-writeback responses into
// two single-register writes (rd, then rd+1) for a one-port register file.
module acc_dualwb_serializer #(
  parameter int DataWidth = 32,
  parameter int Depth     = 2
) (
  input logic                    clk_i,
  input logic                    rst_i,
  acc_dualwb_serializer_if.slave bus
);
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);

  localparam logic [0:0] STATE_FIRST  = 1'b0;
  localparam logic [0:0] STATE_SECOND = 1'b1;

  typedef struct packed {
    logic [2*DataWidth-1:0] data;
    logic                   dualwb;
    logic [DataWidth-1:0]   hart_id;
    logic [4:0]             rd;
    logic                   error;
  } entry_t;

  entry_t entry_mem [Depth];

  logic [PtrWidth-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrWidth-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CntWidth-1:0] cnt_reg, cnt_next;
  logic [0:0]          state_reg, state_next;

  entry_t head;
  entry_t wr_entry;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   out_fire;
  logic   beat_last;
  logic   in_second;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign full      = (cnt_reg == CntFull);
  assign empty     = (cnt_reg == '0);
  assign in_second = (state_reg == STATE_SECOND);

  // Full means no accept, even if the head pops this cycle: in_ready stays
  // a pure function of registered state.
  assign push = bus.in_valid && !full;

  assign head     = entry_mem[rd_ptr_reg];
  assign wr_entry = '{data:    bus.in_data,
                      dualwb:  bus.in_dualwb,
                      hart_id: bus.in_hart_id,
                      rd:      bus.in_rd,
                      error:   bus.in_error};

  // Errored responses always collapse to one beat regardless of dualwb.
  assign beat_last = in_second || !(head.dualwb && !head.error);
  assign out_fire  = !empty && bus.out_ready;
  assign pop       = out_fire && beat_last;

  assign bus.in_ready    = !full;
  assign bus.out_valid   = !empty;
  assign bus.out_last    = !empty && beat_last;
  assign bus.out_data    = in_second ? head.data[2*DataWidth-1:DataWidth]
                                     : head.data[DataWidth-1:0];
  assign bus.out_rd      = in_second ? head.rd + 5'd1 : head.rd;
  assign bus.out_hart_id = head.hart_id;
  assign bus.out_error   = head.error;
  assign bus.busy        = !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;
    state_next  = state_reg;

    if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);

    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase

    if (out_fire) begin
      if (!in_second && !beat_last) state_next = STATE_SECOND;
      else                          state_next = STATE_FIRST;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      state_reg  <= STATE_FIRST;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
      state_reg  <= state_next;
    end
  end

  // Storage is left unreset; the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) entry_mem[wr_ptr_reg] <= wr_entry;
  end
endmodule

// File: tb/tb_acc_dualwb_serializer.sv
// Directed and randomized checks of acc_dualwb_serializer against a
// response-level queue model of the expected writeback beats.
module tb_acc_dualwb_serializer;
  localparam int DataWidth = 32;
  localparam int Depth     = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] hart;
    logic [4:0]  rd;
    logic        err;
    logic        last;
  } beat_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  acc_dualwb_serializer_if #(.DataWidth(DataWidth)) bus ();

  acc_dualwb_serializer #(
    .DataWidth(DataWidth),
    .Depth    (Depth)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  int    check_count = 0;
  int    pass_count  = 0;
  int    resp_cnt    = 0;
  bit    verbose     = 1'b1;
  bit    acc;
  beat_t exp_q [$];

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  function automatic beat_t observed_beat();
    return '{data: bus.out_data, hart: bus.out_hart_id, rd: bus.out_rd,
             err: bus.out_error, last: bus.out_last};
  endfunction

  // A response expands to one beat, or two (rd, rd+1) when dual and error-free.
  function automatic void model_push(input logic [63:0] d, input logic dual,
                                     input logic [31:0] h, input logic [4:0] rd,
                                     input logic e);
    logic [4:0] rd_hi;
    rd_hi = rd + 5'd1;
    if (dual && !e) begin
      exp_q.push_back('{data: d[31:0], hart: h, rd: rd, err: e, last: 1'b0});
      exp_q.push_back('{data: d[63:32], hart: h, rd: rd_hi, err: e, last: 1'b1});
    end else begin
      exp_q.push_back('{data: d[31:0], hart: h, rd: rd, err: e, last: 1'b1});
    end
  endfunction

  task automatic send(input logic [63:0] d, input logic dual, input logic [31:0] h,
                      input logic [4:0] rd, input logic e);
    bus.in_data    = d;
    bus.in_dualwb  = dual;
    bus.in_hart_id = h;
    bus.in_rd      = rd;
    bus.in_error   = e;
    bus.in_valid   = 1'b1;
  endtask

  // One clock: score the beat leaving this edge, then update the model and
  // check occupancy, handshake and stall-stability observables.
  task automatic tick(output bit accepted);
    bit          inf, outf, stall, pop_resp;
    beat_t       pre, exp_b;
    logic [63:0] d;
    logic        dual, e;
    logic [31:0] h;
    logic [4:0]  rd;
    inf   = bus.in_valid && bus.in_ready;
    outf  = bus.out_valid && bus.out_ready;
    stall = bus.out_valid && !bus.out_ready;
    pre   = observed_beat();
    d = bus.in_data; dual = bus.in_dualwb; h = bus.in_hart_id; rd = bus.in_rd; e = bus.in_error;
    pop_resp = 1'b0;
    if (outf) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 128'(1), 128'(0));
      end else begin
        exp_b = exp_q.pop_front();
        check("beat", 128'(pre), 128'(exp_b));
        pop_resp = exp_b.last;
        if (verbose)
          $display("beat rd=%0d data=%08h hart=%0h err=%0b last=%0b",
                   pre.rd, pre.data, pre.hart, pre.err, pre.last);
      end
    end
    @(posedge clk_i);
    #1;
    if (inf) begin
      model_push(d, dual, h, rd, e);
      resp_cnt++;
      if (verbose) $display("accept rd=%0d data=%016h dual=%0b err=%0b", rd, d, dual, e);
    end
    if (pop_resp) resp_cnt--;
    if (stall) begin
      check("stall_valid", 128'(bus.out_valid), 128'(1));
      check("stall_beat", 128'(observed_beat()), 128'(pre));
    end
    check("in_ready", 128'(bus.in_ready), 128'(resp_cnt != Depth));
    check("busy", 128'(bus.busy), 128'(resp_cnt != 0));
    check("out_valid", 128'(bus.out_valid), 128'(resp_cnt != 0));
    accepted = inf;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    resp_cnt = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && resp_cnt != 0; i++) tick(acc);
    check({tag, "_drained"}, 128'(resp_cnt), 128'(0));
    check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int sent;
    int cycles;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_dualwb  = 1'b0;
    bus.in_hart_id = '0;
    bus.in_rd      = '0;
    bus.in_error   = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_out_last", 128'(bus.out_last), 128'(0));

    // Single response
    bus.out_ready = 1'b1;
    send(64'h0000_0000_0000_00AA, 1'b0, 32'h1, 5'd5, 1'b0);
    tick(acc);
    check("single_accept", 128'(acc), 128'(1));
    bus.in_valid = 1'b0;
    check("single_rd", 128'(bus.out_rd), 128'(5));
    check("single_data", 128'(bus.out_data), 128'(32'hAA));
    check("single_last", 128'(bus.out_last), 128'(1));
    tick(acc);
    check("single_busy_clear", 128'(bus.busy), 128'(0));

    // Dual response
    send(64'h2222_2222_1111_1111, 1'b1, 32'h2, 5'd10, 1'b0);
    tick(acc);
    bus.in_valid = 1'b0;
    check("dual_b0_rd", 128'(bus.out_rd), 128'(10));
    check("dual_b0_data", 128'(bus.out_data), 128'(32'h1111_1111));
    check("dual_b0_last", 128'(bus.out_last), 128'(0));
    tick(acc);
    check("dual_b1_rd", 128'(bus.out_rd), 128'(11));
    check("dual_b1_data", 128'(bus.out_data), 128'(32'h2222_2222));
    check("dual_b1_last", 128'(bus.out_last), 128'(1));
    tick(acc);

    // rd wrap and error collapse
    send(64'hBBBB_0002_AAAA_0001, 1'b1, 32'h3, 5'd31, 1'b0);
    tick(acc);
    bus.in_valid = 1'b0;
    tick(acc);
    check("wrap_rd", 128'(bus.out_rd), 128'(0));
    check("wrap_last", 128'(bus.out_last), 128'(1));
    tick(acc);
    send(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 32'h4, 5'd7, 1'b1);
    tick(acc);
    bus.in_valid = 1'b0;
    check("err_rd", 128'(bus.out_rd), 128'(7));
    check("err_flag", 128'(bus.out_error), 128'(1));
    check("err_last", 128'(bus.out_last), 128'(1));
    tick(acc);
    check("err_one_beat", 128'(bus.out_valid), 128'(0));

    // Full FIFO under stall
    bus.out_ready = 1'b0;
    send(64'h0000_0000_0000_0A0A, 1'b0, 32'h5, 5'd1, 1'b0);
    tick(acc);
    send(64'h0000_0B02_0000_0B01, 1'b1, 32'h6, 5'd2, 1'b0);
    tick(acc);
    send(64'h0000_0000_0000_0C0C, 1'b0, 32'h7, 5'd4, 1'b0);
    tick(acc);
    check("full_reject", 128'(acc), 128'(0));
    check("full_in_ready", 128'(bus.in_ready), 128'(0));
    repeat (9) tick(acc);
    check("stall_head_rd", 128'(bus.out_rd), 128'(1));
    bus.out_ready = 1'b1;
    tick(acc);
    check("pop_edge_no_accept", 128'(acc), 128'(0));
    check("after_pop_in_ready", 128'(bus.in_ready), 128'(1));
    tick(acc);
    check("third_accept", 128'(acc), 128'(1));
    bus.in_valid = 1'b0;
    drain("stall");

    // Reset while in the second beat with two entries held
    bus.out_ready = 1'b0;
    send(64'h0000_2002_0000_2001, 1'b1, 32'h8, 5'd20, 1'b0);
    tick(acc);
    send(64'h0000_2102_0000_2101, 1'b1, 32'h9, 5'd21, 1'b0);
    tick(acc);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick(acc);
    bus.out_ready = 1'b0;
    check("second_rd", 128'(bus.out_rd), 128'(21));
    do_reset();
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_busy", 128'(bus.busy), 128'(0));
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    send(64'h0000_3002_0000_3001, 1'b1, 32'hA, 5'd3, 1'b0);
    tick(acc);
    bus.in_valid = 1'b0;
    check("fresh_rd", 128'(bus.out_rd), 128'(3));
    check("fresh_data", 128'(bus.out_data), 128'(32'h3001));
    check("fresh_last", 128'(bus.out_last), 128'(0));
    drain("fresh");

    // Randomized traffic
    verbose = 1'b0;
    sent    = 0;
    cycles  = 0;
    while ((sent < 1000 || resp_cnt != 0 || bus.in_valid) && cycles < 30000) begin
      if (!bus.in_valid && sent < 1000 && $urandom_range(3) != 0)
        send({$urandom, $urandom}, 1'($urandom_range(1)), $urandom,
             5'($urandom_range(31)), 1'($urandom_range(7) == 0));
      bus.out_ready = ($urandom_range(2) != 0);
      tick(acc);
      cycles++;
      if (acc) begin
        sent++;
        bus.in_valid = 1'b0;
      end
    end
    check("random_in_time", 128'(cycles < 30000), 128'(1));
    check("random_sent", 128'(sent), 128'(1000));
    check("random_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("random phase: %0d responses in %0d cycles", sent, cycles);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
